cmd_decoder: RTL and testbench

Byte-level command decoder between the SPI byte bridge and the PWM register file. It turns each chip-select framed byte stream into single-cycle `read`/`write` strobes with a 6-bit address and write data. For reads, it captures the register file's combinational `data_read` and returns it as the next transmit byte.

---
 rtl/cmd_decoder_pkg.sv | 8 +
 rtl/cmd_decoder.sv | 95 +++++++++
 tb/tb_cmd_decoder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cmd_decoder_pkg.sv
// cmd_decoder_pkg: shared widths, command bit positions and FSM states for the SPI command decoder
package cmd_decoder_pkg;
  localparam int ADDR_W       = 6;
  localparam int DATA_W       = 8;
  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_RSVD_BIT = 6;
  typedef enum logic [2:0] {IDLE, WDATA, RACC, RDATA, DONE} state_t;
endpackage

// File: rtl/cmd_decoder.sv
// cmd_decoder: turns chip-select framed SPI bytes into register read/write strobes; CMD_DECODER_BURST_EN enables auto-increment bursts
module cmd_decoder #(
  parameter int ADDR_W = cmd_decoder_pkg::ADDR_W,
  parameter int DATA_W = cmd_decoder_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_active,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_byte,
  output logic [DATA_W-1:0] tx_byte,
  output logic              tx_valid,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_write,
  input  logic [DATA_W-1:0] data_read,
  output logic              cmd_err
);
  import cmd_decoder_pkg::*;
  state_t              state_q;
  logic                read_q, write_q, tx_valid_q, cmd_err_q;
  logic                act_q, blk_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_write_q, tx_byte_q;
  // Command FSM; blk_q keeps a frame interrupted by reset ignored until chip-select cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      tx_valid_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
      addr_q       <= '0;
      data_write_q <= '0;
      tx_byte_q    <= '0;
      act_q        <= 1'b0;
      blk_q        <= 1'b1;
    end else begin
      act_q      <= frame_active;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      tx_valid_q <= read_q;
      if (read_q) tx_byte_q <= data_read;
`ifdef CMD_DECODER_BURST_EN
      if (write_q) addr_q <= addr_q + 1'b1;
`endif
      if (frame_active && !act_q) cmd_err_q <= 1'b0;
      if (!frame_active) begin
        state_q <= IDLE;
        blk_q   <= 1'b0;
      end else if (!blk_q) begin
        case (state_q)
          IDLE: if (rx_valid) begin
            addr_q <= rx_byte[ADDR_W-1:0];
            if (rx_byte[CMD_RSVD_BIT]) begin
              cmd_err_q <= 1'b1;
              state_q   <= DONE;
            end else if (rx_byte[CMD_RW_BIT]) begin
              state_q <= WDATA;
            end else begin
              read_q  <= 1'b1;
              state_q <= RACC;
            end
          end
          WDATA: if (rx_valid) begin
            write_q      <= 1'b1;
            data_write_q <= rx_byte;
`ifndef CMD_DECODER_BURST_EN
            state_q      <= DONE;
`endif
          end
          RACC: state_q <= RDATA;
          RDATA: if (rx_valid) begin
`ifdef CMD_DECODER_BURST_EN
            addr_q  <= addr_q + 1'b1;
            read_q  <= 1'b1;
            state_q <= RACC;
`else
            state_q <= DONE;
`endif
          end
          default: ;
        endcase
      end
    end
  end
  assign tx_byte    = tx_byte_q;
  assign tx_valid   = tx_valid_q;
  assign read       = read_q;
  assign write      = write_q;
  assign addr       = addr_q;
  assign data_write = data_write_q;
  assign cmd_err    = cmd_err_q;
endmodule

// File: tb/tb_cmd_decoder.sv
// tb_cmd_decoder: directed checks of command decoding, latency, errors, aborts, bursts and reset
module tb_cmd_decoder;
  logic       clk = 1'b0, rst = 1'b1, frame_active = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] tx_byte, data_write, data_read;
  logic       tx_valid, read, write, cmd_err;
  logic [5:0] addr;
  logic [7:0] mem [64] = '{default: 8'h00};
  int         n_cmp = 0, n_bad = 0, wcnt = 0, rcnt = 0, w0 = 0, r0 = 0;
  always #5 clk = ~clk;
  cmd_decoder dut (
    .clk(clk), .rst(rst), .frame_active(frame_active), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .read(read), .write(write), .addr(addr),
    .data_write(data_write), .data_read(data_read), .cmd_err(cmd_err)
  );
  // register file stand-in: combinational read, clocked write
  assign data_read = mem[addr];
  always @(posedge clk) if (write) mem[addr] <= data_write;
  always @(negedge clk) begin
    if (write) wcnt++;
    if (read) rcnt++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic open_frame();
    frame_active = 1'b1;
    tick(2);
  endtask
  task automatic close_frame();
    tick(2);
    frame_active = 1'b0;
    tick(3);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_tx_byte"}, tx_byte, 0);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_read"}, read, 0);
    check({tag, "_write"}, write, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_data_write"}, data_write, 0);
    check({tag, "_cmd_err"}, cmd_err, 0);
  endtask
  initial begin
    tick(3);
    check_zero("rst");
    rst = 1'b0;
    tick(2);
    open_frame();
    send(8'h8A);
    check("wcmd_no_strobe", {read, write}, 0);
    tick(3);
    send(8'h05);
    check("w_strobe", write, 1);
    check("w_addr", addr, 8'h0A);
    check("w_data", data_write, 8'h05);
    check("w_no_read", read, 0);
    tick(1);
    check("w_one_cycle", write, 0);
    close_frame();
    open_frame();
    send(8'h0A);
    check("r_strobe", read, 1);
    check("r_addr", addr, 8'h0A);
    check("r_no_write", write, 0);
    tick(1);
    check("r_tx_valid", tx_valid, 1);
    check("r_tx_byte", tx_byte, 8'h05);
    check("r_one_cycle", read, 0);
    tick(1);
    check("r_tx_valid_pulse", tx_valid, 0);
    tick(1);
    r0 = rcnt;
    send(8'hFF);
    tick(3);
`ifdef CMD_DECODER_BURST_EN
    check("r_dummy_reads", rcnt - r0, 1);
`else
    check("r_dummy_reads", rcnt - r0, 0);
`endif
    close_frame();
    open_frame();
    send(8'h80);
    tick(3);
    send(8'h3C);
    check("pre_strobe", write, 1);
    check("pre_addr", addr, 0);
    check("pre_data", data_write, 8'h3C);
    close_frame();
    open_frame();
    send(8'h00);
    check("r0_strobe", read, 1);
    check("r0_addr", addr, 0);
    tick(1);
    check("r0_tx_valid", tx_valid, 1);
    check("r0_tx_byte", tx_byte, 8'h3C);
    tick(2);
    send(8'hFF);
    close_frame();
    open_frame();
    w0 = wcnt;
    send(8'hC2);
    check("rsvd_cmd_err", cmd_err, 1);
    tick(3);
    send(8'h01);
    tick(2);
    check("rsvd_no_write", wcnt - w0, 0);
    check("rsvd_err_held", cmd_err, 1);
    close_frame();
    check("rsvd_err_sticky", cmd_err, 1);
    frame_active = 1'b1;
    tick(1);
    check("rsvd_err_clear", cmd_err, 0);
    frame_active = 1'b0;
    tick(2);
    open_frame();
    w0 = wcnt;
    send(8'h83);
    tick(1);
    frame_active = 1'b0;
    tick(1);
    send(8'h22);
    tick(3);
    check("abort_no_write", wcnt - w0, 0);
    open_frame();
    send(8'h83);
    tick(3);
    send(8'h11);
    check("abort_next_strobe", write, 1);
    check("abort_next_addr", addr, 8'h03);
    check("abort_next_data", data_write, 8'h11);
    close_frame();
    open_frame();
    w0 = wcnt;
    send(8'hBF);
    tick(3);
    send(8'hA1);
    check("burst_w1_strobe", write, 1);
    check("burst_w1_addr", addr, 8'h3F);
    check("burst_w1_data", data_write, 8'hA1);
    tick(3);
    send(8'hA2);
`ifdef CMD_DECODER_BURST_EN
    check("burst_w2_strobe", write, 1);
    check("burst_w2_addr", addr, 8'h00);
    check("burst_w2_data", data_write, 8'hA2);
`else
    check("burst_w2_strobe", write, 0);
`endif
    close_frame();
`ifdef CMD_DECODER_BURST_EN
    check("burst_write_count", wcnt - w0, 2);
`else
    check("burst_write_count", wcnt - w0, 1);
`endif
    open_frame();
    send(8'h85);
    tick(2);
    rst = 1'b1;
    tick(1);
    check_zero("midrst");
    rst = 1'b0;
    w0 = wcnt;
    tick(2);
    send(8'h44);
    tick(3);
    send(8'h55);
    tick(3);
    check("midrst_no_write", wcnt - w0, 0);
    close_frame();
    open_frame();
    send(8'h85);
    tick(3);
    send(8'h66);
    check("postrst_strobe", write, 1);
    check("postrst_addr", addr, 8'h05);
    check("postrst_data", data_write, 8'h66);
    close_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
